// File: rtl/i2c_slave_byte_engine.sv
// I2C slave byte engine: START/STOP detection, 7-bit address match, byte moves to/from the register block.
// Latency: bus events and strobes appear 1 clk after the sampled edge; SDA drive changes 1 clk after SCL fall.
// Backpressure: none; the master paces everything through SCL, and read data must arrive the cycle after rd_req_o.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   sda_filt_i, scl_filt_i  filtered bus lines
//   dev_addr_i              7-bit slave address (static while bus idle)
//   sda_oe_o                1 = pull SDA low (ACK or read data 0)
//   start_o, stop_o         1-cycle bus event pulses
//   wr_data_o/wr_valid_o/wr_first_o  received byte, strobe, first-byte-after-address flag
//   rd_req_o, rd_data_i     read byte request; data sampled the cycle after the request
//   busy_o                  addressed and active
module i2c_slave_byte_engine #(
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sda_filt_i,
  input  logic              scl_filt_i,
  input  logic [ADDR_W-1:0] dev_addr_i,
  output logic              sda_oe_o,
  output logic              start_o,
  output logic              stop_o,
  output logic [7:0]        wr_data_o,
  output logic              wr_valid_o,
  output logic              wr_first_o,
  output logic              rd_req_o,
  input  logic [7:0]        rd_data_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_sda_q, r_scl_q;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic [7:0] r_tx, w_tx_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_ack_on, w_ack_on_nxt;   // ACK currently being driven (between the two falls)
  logic       r_first, w_first_nxt;     // next written byte is the register pointer
  logic       r_oe, w_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_start, r_stop;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic       r_wr_valid, w_wr_valid_nxt;
  logic       r_wr_first, w_wr_first_nxt;
  logic       r_rd_req, w_rd_req_nxt;
  logic       r_rd_load;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;

  assign w_scl_rise = ~r_scl_q & scl_filt_i;
  assign w_scl_fall = r_scl_q & ~scl_filt_i;
  assign w_start    = r_scl_q & scl_filt_i & r_sda_q & ~sda_filt_i;
  assign w_stop     = r_scl_q & scl_filt_i & ~r_sda_q & sda_filt_i;
  // Byte as it stands including the bit being sampled on this rise
  assign w_byte     = {r_shift, sda_filt_i};

  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_rw_nxt       = r_rw;
    w_ack_on_nxt   = r_ack_on;
    w_first_nxt    = r_first;
    w_oe_nxt       = r_oe;
    w_busy_nxt     = r_busy;
    w_wr_data_nxt  = r_wr_data;
    w_wr_valid_nxt = 1'b0;
    w_wr_first_nxt = 1'b0;
    w_rd_req_nxt   = 1'b0;

    // Register block answers the cycle after the request
    if (r_rd_load) w_tx_nxt = rd_data_i;

    // START/STOP require SCL high in both samples, so they never coincide with an SCL edge
    if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_bitcnt_nxt = 4'd0;
      w_oe_nxt     = 1'b0;
      w_ack_on_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_oe_nxt     = 1'b0;
      w_busy_nxt   = 1'b0;
      w_ack_on_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte[6:0];
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              if (w_byte[7:1] == dev_addr_i) begin
                w_state_nxt  = S_ADDR_ACK;
                w_busy_nxt   = 1'b1;
                w_rw_nxt     = w_byte[0];
                w_first_nxt  = 1'b1;
                w_ack_on_nxt = 1'b0;
              end else begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_on) begin
              w_oe_nxt     = 1'b1;
              w_ack_on_nxt = 1'b1;
              if (r_state == S_ADDR_ACK && r_rw) w_rd_req_nxt = 1'b1;
            end else begin
              w_ack_on_nxt = 1'b0;
              w_bitcnt_nxt = 4'd0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                // ACK release and first read bit share this fall
                w_oe_nxt     = ~r_tx[7];
                w_tx_nxt     = {r_tx[6:0], 1'b0};
                w_bitcnt_nxt = 4'd1;
                w_state_nxt  = S_RD_BYTE;
              end else begin
                w_oe_nxt    = 1'b0;
                w_state_nxt = S_WR_BYTE;
              end
            end
          end
        end
        S_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte[6:0];
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              w_wr_data_nxt  = w_byte;
              w_wr_valid_nxt = 1'b1;
              w_wr_first_nxt = r_first;
              w_first_nxt    = 1'b0;
              w_ack_on_nxt   = 1'b0;
              w_state_nxt    = S_WR_ACK;
            end
          end
        end
        S_RD_BYTE: begin
          // r_bitcnt counts bits already put on the bus
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RD_ACK;
            end else begin
              w_oe_nxt     = ~r_tx[7];
              w_tx_nxt     = {r_tx[6:0], 1'b0};
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!sda_filt_i) begin
              w_rd_req_nxt = 1'b1;
              w_bitcnt_nxt = 4'd0;
              w_state_nxt  = S_RD_BYTE;
            end else begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_sda_q    <= 1'b1;
      r_scl_q    <= 1'b1;
      r_bitcnt   <= 4'd0;
      r_shift    <= 7'd0;
      r_tx       <= 8'd0;
      r_rw       <= 1'b0;
      r_ack_on   <= 1'b0;
      r_first    <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_wr_data  <= 8'd0;
      r_wr_valid <= 1'b0;
      r_wr_first <= 1'b0;
      r_rd_req   <= 1'b0;
      r_rd_load  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sda_q    <= sda_filt_i;
      r_scl_q    <= scl_filt_i;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_rw       <= w_rw_nxt;
      r_ack_on   <= w_ack_on_nxt;
      r_first    <= w_first_nxt;
      r_oe       <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_start    <= w_start;
      r_stop     <= w_stop;
      r_wr_data  <= w_wr_data_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_first <= w_wr_first_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_rd_load  <= r_rd_req;
    end
  end

  assign sda_oe_o   = r_oe;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign wr_data_o  = r_wr_data;
  assign wr_valid_o = r_wr_valid;
  assign wr_first_o = r_wr_first;
  assign rd_req_o   = r_rd_req;
  assign busy_o     = r_busy;

endmodule
